// File: rtl/adder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_pkg : shared byte width, sequencer state type and index-width helper
// Revision  : 1.0
// ---------------------------------------------------------------------------
package adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Byte index counter never collapses to zero bits when there is one byte.
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multibyte_add_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multibyte_add_seq_if : requester-side bundle of the multibyte add sequencer
// Revision             : 1.0
// ---------------------------------------------------------------------------
interface multibyte_add_seq_if #(
  parameter int NBYTES = 4
) ();

  logic                                start;
  logic [adder_pkg::BYTE_W*NBYTES-1:0] a;
  logic [adder_pkg::BYTE_W*NBYTES-1:0] b;
  logic                                cin;
  logic                                busy;
  logic                                done;
  logic [adder_pkg::BYTE_W*NBYTES-1:0] sum;
  logic                                cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface
`default_nettype wire

// File: rtl/binary_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// binary_adder : shared byte-wide ripple adder with carry in/out
// Revision     : 1.0
// ---------------------------------------------------------------------------
module binary_adder
  import adder_pkg::*;
(
  input  logic [BYTE_W-1:0] A,
  input  logic [BYTE_W-1:0] B,
  input  logic              Cin,
  output logic [BYTE_W-1:0] SUM,
  output logic              Cout
);

  assign {Cout, SUM} = {1'b0, A} + {1'b0, B} + {{BYTE_W{1'b0}}, Cin};

endmodule
`default_nettype wire

// File: rtl/multibyte_add_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multibyte_add_seq : N-byte add, one byte per clock LSB first on one adder
// Revision          : 1.0
// ---------------------------------------------------------------------------
module multibyte_add_seq
  import adder_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  multibyte_add_seq_if.slave  bus
);

  localparam int                W        = BYTE_W * NBYTES;
  localparam int                IDX_W    = idx_width(NBYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);

  generate
    if (NBYTES < 1 || NBYTES > 16) begin : g_bad_nbytes
      $error("multibyte_add_seq: NBYTES out of range 1..16");
    end
  endgenerate

  seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      sum_q, sum_d;
  logic              cout_q, cout_d;

  logic              busy_o_w, done_o_w;
  logic              load, step, last;

  logic [BYTE_W-1:0] add_a, add_b, add_sum;
  logic              add_cout;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs and datapath controls
  always_comb begin
    busy_o_w = 1'b0;
    done_o_w = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    case (state_q)
      IDLE:    load = bus.start;
      RUN: begin
        busy_o_w = 1'b1;
        step     = 1'b1;
      end
      DONE: begin
        busy_o_w = 1'b1;
        done_o_w = 1'b1;
      end
      default: ;
    endcase
  end

  assign last = (idx_q == LAST_IDX);

  assign add_a = a_q[BYTE_W*int'(idx_q) +: BYTE_W];
  assign add_b = b_q[BYTE_W*int'(idx_q) +: BYTE_W];

  binary_adder u_adder (
    .A    (add_a),
    .B    (add_b),
    .Cin  (carry_q),
    .SUM  (add_sum),
    .Cout (add_cout)
  );

  // cout is only refreshed by the final byte, so it survives the next start.
  always_comb begin
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (load) begin
      a_d     = bus.a;
      b_d     = bus.b;
      carry_d = bus.cin;
      sum_d   = '0;
      idx_d   = '0;
    end else if (step) begin
      sum_d[BYTE_W*int'(idx_q) +: BYTE_W] = add_sum;
      carry_d = add_cout;
      if (last) begin
        cout_d = add_cout;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = busy_o_w;
  assign bus.done = done_o_w;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
`default_nettype wire

// File: doc/multibyte_add_seq.md
# multibyte_add_seq

Sequencer that performs an N-byte addition by time-multiplexing a single 8-bit `binary_adder`, one byte per clock, least significant byte first. The carry is chained through a register between bytes. It sits between a requester presenting wide operands with a start pulse and the shared 8-bit adder datapath, and returns the wide sum with a one-cycle done pulse.

## Interface
Parameters:
- `NBYTES`, default 4: number of 8-bit slices; operand width is 8*NBYTES. Legal range 1..16.

Ports:
- `clk`  in  1  : the single clock; all state updates on its rising edge.
- `rst`  in  1  : reset, synchronous and active-high.
- `start`  in  1  : request pulse; honoured only in IDLE.
- `a`  in  8*NBYTES  : operand A; sampled only on the accepted start cycle.
- `b`  in  8*NBYTES  : operand B; sampled only on the accepted start cycle.
- `cin`  in  1  : carry into byte 0; sampled with the operands.
- `busy`  out  1  : high while in RUN or DONE.
- `done`  out  1  : one-cycle pulse, high in DONE only.
- `sum`  out  8*NBYTES  : result register.
- `cout`  out  1  : carry out of byte NBYTES-1.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - If `start`=1: latch `a`, `b` into operand registers, latch `cin` into the carry register, clear `sum` to 0, set the byte index to 0, and go to RUN.
  - Otherwise stay in IDLE.
- **RUN**, byte index i:
  - The adder is driven with `a_reg[8i+7:8i]`, `b_reg[8i+7:8i]` and the carry register.
  - On the clock edge, the adder SUM is written into `sum[8i+7:8i]` and its Cout into the carry register.
  - If i=NBYTES-1: `cout` takes the adder Cout and the state goes to DONE. Otherwise i increments.
- **DONE**: assert `done` for one cycle, then go to IDLE unconditionally.
- `start` is ignored in RUN and in DONE. It is not queued. A requester must re-assert `start` in IDLE.
- `a`, `b` and `cin` may change freely after the start cycle without affecting the result.
- `sum` and `cout` hold their value from DONE through IDLE until the next accepted start. On that start, `sum` clears to 0 and `cout` keeps its old value until the final byte is written.
- Arithmetic is unsigned modulo 2^(8*NBYTES), with the carry out reported on `cout`. Overflow is not flagged separately.
- The byte index counter is $clog2(NBYTES) bits wide, with a minimum of 1 bit. It never exceeds NBYTES-1.

## Timing
- Reset: state=IDLE; `busy`=0, `done`=0, `sum`=0, `cout`=0; carry register, index and operand registers all 0.
- Reset applies on the next rising edge in any state, including mid-RUN. A partial `sum` is discarded (cleared to 0) and no `done` is produced.
- Latency, with start accepted at edge E0:
  - `busy` goes high after E0.
  - Byte i is written at edge E(i+1).
  - DONE is entered after edge E(NBYTES).
  - `done`=1 during the cycle between edges E(NBYTES) and E(NBYTES+1).
  - `busy` falls after E(NBYTES+1).
- Minimum start-to-start spacing is NBYTES+2 cycles. A start held high continuously is accepted every NBYTES+2 cycles.
- NBYTES=1: a single RUN cycle, then DONE.
- A carry generated in byte i is consumed in byte i+1 on the next cycle. There is no combinational path from `a`, `b` or `cin` to any output.

## Structure
- Shared package `adder_pkg`:
  - `BYTE_W` = 8.
  - State enum `seq_state_t` {IDLE, RUN, DONE}.
- Sub-module: exactly one instance of the existing `binary_adder` (A, B, Cin, SUM, Cout, all 8-bit except the carries). The sequencer contains no adder logic of its own.
- Byte slicing uses indexed part-selects on the operand registers. The outputs are registers.

## Test plan
All scenarios use NBYTES=4.
1. `a`=0x00000001, `b`=0x00000001, `cin`=0, start for 1 cycle -> `done` pulses exactly 5 cycles after the start edge; `sum`=0x00000002, `cout`=0; `busy` high for 5 cycles.
2. `a`=0xFFFFFFFF, `b`=0x00000000, `cin`=1 -> `sum`=0x00000000, `cout`=1. This checks that the carry ripples through all 4 byte cycles.
3. `a`=0x80FF00FF, `b`=0x80010001, `cin`=0 -> `sum`=0x01000100, `cout`=1. Change `a`/`b` to random values on the cycle after start; the result must be unchanged.
4. Start accepted, then re-assert start during RUN and during DONE -> no second operation occurs. Start in the following IDLE cycle is accepted with new operands 0x00000003+0x00000004 -> `sum`=0x00000007.
5. Assert `rst` for 1 cycle in the third RUN cycle -> next cycle: IDLE, `busy`=0, `sum`=0, `cout`=0, no `done` pulse. A subsequent start 0x00000001+0x00000001 completes normally.
6. Hold `start`=1 continuously with 0x000000FF+0x00000001 -> `done` pulses every 6 cycles, with `sum`=0x00000100 and `cout`=0 each time.
